// File: rtl/rename_map_if.sv
// Rename-stage bundle: rename group in, freelist read/write side, commit group in,
// renamed tags out. The DUT takes the slave view; a driver takes the master view.
interface rename_map_if #(
  parameter int ARCH   = 32,
  parameter int PHYS   = 64,
  parameter int WIDTH  = 4,
  parameter int COMMIT = 4
);
  localparam int AREG = $clog2(ARCH);
  localparam int TAG  = $clog2(PHYS);

  logic                          flush_;
  logic [WIDTH-1:0]              ren_;
  logic [WIDTH-1:0][AREG-1:0]    src1;
  logic [WIDTH-1:0][AREG-1:0]    src2;
  logic [WIDTH-1:0][AREG-1:0]    dst;
  logic [WIDTH-1:0][TAG-1:0]     fl_tag;
  logic [WIDTH-1:0]              fl_v;
  logic                          fl_busy;
  logic [WIDTH-1:0]              alloc_;
  logic                          stall;
  logic [WIDTH-1:0]              out_v;
  logic [WIDTH-1:0][TAG-1:0]     psrc1;
  logic [WIDTH-1:0][TAG-1:0]     psrc2;
  logic [WIDTH-1:0]              ps1_m;
  logic [WIDTH-1:0]              ps2_m;
  logic [WIDTH-1:0][TAG-1:0]     pdst;
  logic [WIDTH-1:0][TAG-1:0]     pold;
  logic [WIDTH-1:0]              pold_m;
  logic [COMMIT-1:0]             cmt_;
  logic [COMMIT-1:0][AREG-1:0]   cmt_dst;
  logic [COMMIT-1:0][TAG-1:0]    cmt_tag;
  logic [COMMIT-1:0]             free_;
  logic [COMMIT-1:0][TAG-1:0]    free_tag;

  modport slave (
    input  flush_, ren_, src1, src2, dst, fl_tag, fl_v, fl_busy,
           cmt_, cmt_dst, cmt_tag,
    output alloc_, stall, out_v, psrc1, psrc2, ps1_m, ps2_m, pdst, pold, pold_m,
           free_, free_tag
  );

  modport master (
    output flush_, ren_, src1, src2, dst, fl_tag, fl_v, fl_busy,
           cmt_, cmt_dst, cmt_tag,
    input  alloc_, stall, out_v, psrc1, psrc2, ps1_m, ps2_m, pdst, pold, pold_m,
           free_, free_tag
  );
endinterface

// File: rtl/rename_map.sv
// Register rename map: speculative + committed maps, intra-group bypass,
// registered rename results and registered free path back to the tag freelist.
module rename_map #(
  parameter int ARCH   = 32,
  parameter int PHYS   = 64,
  parameter int WIDTH  = 4,
  parameter int COMMIT = 4
) (
  input  logic         clk,
  input  logic         reset,
  rename_map_if.slave  bus
);
  localparam int TAG = $clog2(PHYS);

  typedef struct packed {
    logic           m;
    logic [TAG-1:0] t;
  } entry_t;

  entry_t spec_q [ARCH];
  entry_t spec_d [ARCH];
  entry_t cmt_q  [ARCH];
  entry_t cmt_d  [ARCH];
  entry_t ren_w  [ARCH];

  entry_t s1_c   [WIDTH];
  entry_t s2_c   [WIDTH];
  entry_t old_c  [WIDTH];

  logic   [WIDTH-1:0]  out_v_q, out_v_d;
  entry_t              psrc1_q [WIDTH], psrc1_d [WIDTH];
  entry_t              psrc2_q [WIDTH], psrc2_d [WIDTH];
  entry_t              pold_q  [WIDTH], pold_d  [WIDTH];
  logic   [TAG-1:0]    pdst_q  [WIDTH], pdst_d  [WIDTH];
  logic   [COMMIT-1:0] free_q, free_d;
  logic   [TAG-1:0]    free_tag_q [COMMIT], free_tag_d [COMMIT];

  logic stall_c;
  logic accept;

  assign stall_c    = bus.fl_busy | (|(~bus.ren_ & ~bus.fl_v));
  assign accept     = ~stall_c & bus.flush_;
  assign bus.stall  = stall_c;
  assign bus.alloc_ = accept ? bus.ren_ : '1;

  // Walking the slots in order over a working copy gives the intra-group
  // bypass for free: each slot sees all lower-slot writes, highest winning.
  always_comb begin
    ren_w = spec_q;
    for (int k = 0; k < WIDTH; k++) begin
      s1_c[k]  = ren_w[bus.src1[k]];
      s2_c[k]  = ren_w[bus.src2[k]];
      old_c[k] = ren_w[bus.dst[k]];
      if (!bus.ren_[k]) begin
        ren_w[bus.dst[k]] = {1'b1, bus.fl_tag[k]};
      end
    end
  end

  // Same walk for commit: the value read before a slot writes is its superseded tag.
  always_comb begin
    cmt_d = cmt_q;
    for (int c = 0; c < COMMIT; c++) begin
      free_d[c]     = 1'b1;
      free_tag_d[c] = '0;
      if (!bus.cmt_[c]) begin
        if (cmt_d[bus.cmt_dst[c]].m) begin
          free_d[c]     = 1'b0;
          free_tag_d[c] = cmt_d[bus.cmt_dst[c]].t;
        end
        cmt_d[bus.cmt_dst[c]] = {1'b1, bus.cmt_tag[c]};
      end
    end
  end

  always_comb begin
    if (!bus.flush_) begin
      spec_d = cmt_d;
    end else if (accept) begin
      spec_d = ren_w;
    end else begin
      spec_d = spec_q;
    end
  end

  always_comb begin
    out_v_d = accept ? ~bus.ren_ : '0;
    for (int k = 0; k < WIDTH; k++) begin
      psrc1_d[k] = accept ? s1_c[k]        : psrc1_q[k];
      psrc2_d[k] = accept ? s2_c[k]        : psrc2_q[k];
      pold_d[k]  = accept ? old_c[k]       : pold_q[k];
      pdst_d[k]  = accept ? bus.fl_tag[k]  : pdst_q[k];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ARCH; i++) begin
        spec_q[i] <= '0;
        cmt_q[i]  <= '0;
      end
      out_v_q <= '0;
      free_q  <= '1;
      for (int k = 0; k < WIDTH; k++) begin
        psrc1_q[k] <= '0;
        psrc2_q[k] <= '0;
        pold_q[k]  <= '0;
        pdst_q[k]  <= '0;
      end
      for (int c = 0; c < COMMIT; c++) begin
        free_tag_q[c] <= '0;
      end
    end else begin
      spec_q     <= spec_d;
      cmt_q      <= cmt_d;
      out_v_q    <= out_v_d;
      free_q     <= free_d;
      psrc1_q    <= psrc1_d;
      psrc2_q    <= psrc2_d;
      pold_q     <= pold_d;
      pdst_q     <= pdst_d;
      free_tag_q <= free_tag_d;
    end
  end

  assign bus.out_v = out_v_q;
  assign bus.free_ = free_q;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_slot_out
    assign bus.psrc1[gi]  = psrc1_q[gi].t;
    assign bus.ps1_m[gi]  = psrc1_q[gi].m;
    assign bus.psrc2[gi]  = psrc2_q[gi].t;
    assign bus.ps2_m[gi]  = psrc2_q[gi].m;
    assign bus.pold[gi]   = pold_q[gi].t;
    assign bus.pold_m[gi] = pold_q[gi].m;
    assign bus.pdst[gi]   = pdst_q[gi];
  end

  for (genvar gi = 0; gi < COMMIT; gi++) begin : g_free_out
    assign bus.free_tag[gi] = free_tag_q[gi];
  end
endmodule

// File: tb/tb_rename_map.sv
// Directed bench for rename_map: rename, bypass, stall, commit/free, flush, reset.
module tb_rename_map;
  localparam int ARCH = 32, PHYS = 64, WIDTH = 4, COMMIT = 4;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  rename_map_if #(.ARCH(ARCH), .PHYS(PHYS), .WIDTH(WIDTH), .COMMIT(COMMIT)) bus ();

  rename_map #(.ARCH(ARCH), .PHYS(PHYS), .WIDTH(WIDTH), .COMMIT(COMMIT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.flush_  = 1'b1;
    bus.ren_    = '1;
    bus.src1    = '0;
    bus.src2    = '0;
    bus.dst     = '0;
    bus.fl_tag  = '0;
    bus.fl_v    = '1;
    bus.fl_busy = 1'b0;
    bus.cmt_    = '1;
    bus.cmt_dst = '0;
    bus.cmt_tag = '0;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    $display("reset released");
    chk("rst_out_v", bus.out_v, 4'b0000);
    chk("rst_free_", bus.free_, 4'b1111);
    chk("rst_pdst0", bus.pdst[0], 0);
    chk("rst_stall", bus.stall, 0);

    // single rename r3 -> ?, r5 -> 7
    bus.ren_ = 4'b1110; bus.src1[0] = 5'd3; bus.dst[0] = 5'd5; bus.fl_tag[0] = 6'd7;
    #1;
    chk("t1_alloc_", bus.alloc_, 4'b1110);
    chk("t1_stall", bus.stall, 0);
    tick(); idle();
    $display("txn1 rename r5->7 out_v=%b pdst0=%0d", bus.out_v, bus.pdst[0]);
    chk("t1_out_v", bus.out_v, 4'b0001);
    chk("t1_ps1_m0", bus.ps1_m[0], 0);
    chk("t1_pdst0", bus.pdst[0], 7);
    chk("t1_pold_m0", bus.pold_m[0], 0);

    // bypass within a group
    bus.ren_ = 4'b1100;
    bus.dst[0] = 5'd5; bus.fl_tag[0] = 6'd9;
    bus.src1[1] = 5'd5; bus.dst[1] = 5'd5; bus.fl_tag[1] = 6'd10;
    tick(); idle();
    $display("txn2 bypass psrc1_1=%0d pold1=%0d", bus.psrc1[1], bus.pold[1]);
    chk("t2_out_v", bus.out_v, 4'b0011);
    chk("t2_psrc1_1", bus.psrc1[1], 9);
    chk("t2_ps1_m1", bus.ps1_m[1], 1);
    chk("t2_pold1", bus.pold[1], 9);
    chk("t2_pold0", bus.pold[0], 7);
    chk("t2_pold_m0", bus.pold_m[0], 1);

    // lookup r5
    bus.ren_ = 4'b1110; bus.src1[0] = 5'd5; bus.dst[0] = 5'd1; bus.fl_tag[0] = 6'd11;
    tick(); idle();
    $display("txn3 lookup r5 psrc1_0=%0d", bus.psrc1[0]);
    chk("t3_psrc1_0", bus.psrc1[0], 10);
    chk("t3_ps1_m0", bus.ps1_m[0], 1);

    // freelist busy stalls
    bus.ren_ = 4'b1110; bus.fl_busy = 1'b1;
    #1;
    chk("busy_stall", bus.stall, 1);
    chk("busy_alloc_", bus.alloc_, 4'b1111);
    tick(); idle();
    $display("txn4 busy stall out_v=%b", bus.out_v);
    chk("busy_out_v", bus.out_v, 4'b0000);

    // stall on missing freelist tag, then retry
    bus.ren_ = 4'b0000; bus.fl_v = 4'b1011;
    for (int k = 0; k < WIDTH; k++) begin
      bus.dst[k] = 5'd6;
      bus.fl_tag[k] = 6'(20 + k);
    end
    bus.src1[0] = 5'd6; bus.src2[3] = 5'd6;
    #1;
    chk("t5_stall", bus.stall, 1);
    chk("t5_alloc_", bus.alloc_, 4'b1111);
    tick();
    $display("txn5 stalled out_v=%b", bus.out_v);
    chk("t5_out_v", bus.out_v, 4'b0000);
    bus.fl_v = 4'b1111;
    #1;
    chk("t5r_stall", bus.stall, 0);
    chk("t5r_alloc_", bus.alloc_, 4'b0000);
    tick(); idle();
    $display("txn6 retry out_v=%b psrc2_3=%0d", bus.out_v, bus.psrc2[3]);
    chk("t5r_out_v", bus.out_v, 4'b1111);
    chk("t5r_ps1_m0", bus.ps1_m[0], 0);
    chk("t5r_pold_m0", bus.pold_m[0], 0);
    chk("t5r_psrc2_3", bus.psrc2[3], 22);
    chk("t5r_ps2_m3", bus.ps2_m[3], 1);
    chk("t5r_pold3", bus.pold[3], 22);
    chk("t5r_pdst2", bus.pdst[2], 22);

    // commit r5 tag 9, then tag 10
    bus.cmt_ = 4'b1110; bus.cmt_dst[0] = 5'd5; bus.cmt_tag[0] = 6'd9;
    tick(); idle();
    $display("txn7 commit r5=9 free_=%b", bus.free_);
    chk("c1_free_", bus.free_, 4'b1111);
    bus.cmt_ = 4'b1110; bus.cmt_dst[0] = 5'd5; bus.cmt_tag[0] = 6'd10;
    tick(); idle();
    $display("txn8 commit r5=10 free_=%b free_tag0=%0d", bus.free_, bus.free_tag[0]);
    chk("c2_free_", bus.free_, 4'b1110);
    chk("c2_free_tag0", bus.free_tag[0], 9);
    tick();
    chk("c2_free_idle", bus.free_, 4'b1111);

    // two commits to r2 in one cycle
    bus.cmt_ = 4'b1110; bus.cmt_dst[0] = 5'd2; bus.cmt_tag[0] = 6'd1;
    tick(); idle();
    chk("c3_free_", bus.free_, 4'b1111);
    bus.cmt_ = 4'b1100;
    bus.cmt_dst[0] = 5'd2; bus.cmt_tag[0] = 6'd4;
    bus.cmt_dst[1] = 5'd2; bus.cmt_tag[1] = 6'd6;
    tick(); idle();
    $display("txn9 dual commit r2 free_=%b tags=%0d,%0d", bus.free_, bus.free_tag[0], bus.free_tag[1]);
    chk("c4_free_", bus.free_, 4'b1100);
    chk("c4_free_tag0", bus.free_tag[0], 1);
    chk("c4_free_tag1", bus.free_tag[1], 4);

    // rename r5 -> 12, then flush (with a commit of r9 in the flush cycle)
    bus.ren_ = 4'b1110; bus.dst[0] = 5'd5; bus.fl_tag[0] = 6'd12;
    tick(); idle();
    bus.flush_ = 1'b0;
    bus.ren_ = 4'b1110; bus.dst[0] = 5'd3; bus.fl_tag[0] = 6'd33;
    bus.cmt_ = 4'b1110; bus.cmt_dst[0] = 5'd9; bus.cmt_tag[0] = 6'd40;
    #1;
    chk("f_alloc_", bus.alloc_, 4'b1111);
    tick(); idle();
    $display("txn10 flush out_v=%b free_=%b", bus.out_v, bus.free_);
    chk("f_out_v", bus.out_v, 4'b0000);
    chk("f_free_", bus.free_, 4'b1111);
    bus.ren_ = 4'b1000;
    bus.src1[0] = 5'd5; bus.src2[0] = 5'd2; bus.dst[0] = 5'd7;  bus.fl_tag[0] = 6'd30;
    bus.src1[1] = 5'd6; bus.src2[1] = 5'd9; bus.dst[1] = 5'd8;  bus.fl_tag[1] = 6'd31;
    bus.src1[2] = 5'd3;                     bus.dst[2] = 5'd10; bus.fl_tag[2] = 6'd32;
    tick(); idle();
    $display("txn11 post-flush psrc1_0=%0d psrc2_0=%0d psrc2_1=%0d", bus.psrc1[0], bus.psrc2[0], bus.psrc2[1]);
    chk("pf_out_v", bus.out_v, 4'b0111);
    chk("pf_psrc1_0", bus.psrc1[0], 10);
    chk("pf_ps1_m0", bus.ps1_m[0], 1);
    chk("pf_psrc2_0", bus.psrc2[0], 6);
    chk("pf_ps1_m1", bus.ps1_m[1], 0);
    chk("pf_psrc2_1", bus.psrc2[1], 40);
    chk("pf_ps1_m2", bus.ps1_m[2], 0);

    // reset in the middle of a rename + commit cycle
    bus.ren_ = 4'b1110; bus.dst[0] = 5'd5; bus.fl_tag[0] = 6'd50;
    bus.cmt_ = 4'b1110; bus.cmt_dst[0] = 5'd5; bus.cmt_tag[0] = 6'd50;
    reset = 1'b1;
    tick(); idle();
    reset = 1'b0;
    $display("txn12 mid reset free_=%b out_v=%b", bus.free_, bus.out_v);
    chk("mr_free_", bus.free_, 4'b1111);
    chk("mr_out_v", bus.out_v, 4'b0000);
    bus.ren_ = 4'b1110; bus.src1[0] = 5'd5; bus.dst[0] = 5'd4; bus.fl_tag[0] = 6'd1;
    tick(); idle();
    $display("txn13 lookup after reset ps1_m0=%b", bus.ps1_m[0]);
    chk("mr_ps1_m0", bus.ps1_m[0], 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rename_map.md
Name: rename_map

Overview:
- Register rename map stage sitting directly downstream of the tag freelist. The freelist runs in scalar mode with DEPTH=PHYS and READ=WIDTH.
- Each cycle, takes up to WIDTH rename requests and consumes freelist read port k for rename slot k. Returns the physical source and destination tags one cycle later.
- Keeps a speculative map and a committed map, used for flush recovery.
- At commit, returns superseded physical tags to the freelist write ports through a registered free path.

Parameters:
- ARCH, 32, number of architectural registers; AREG = $clog2(ARCH).
- PHYS, 64, number of physical registers; TAG = $clog2(PHYS). Equals the freelist DEPTH.
- WIDTH, 4, rename slots per cycle. Equals the freelist READ.
- COMMIT, 4, commit slots per cycle. Equals the freelist WRITE.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- flush_  in  1  active-low; restore speculative map from committed map
- ren_  in  WIDTH  active-low rename request per slot
- src1, src2, dst  in  WIDTH x AREG  architectural operands
- fl_tag  in  WIDTH x TAG  freelist rd
- fl_v  in  WIDTH  freelist v
- fl_busy  in  1  freelist busy
- alloc_  out  WIDTH  active-low, to freelist re_
- stall  out  1  rename group not accepted this cycle
- out_v  out  WIDTH  registered slot valid
- psrc1, psrc2  out  WIDTH x TAG  registered source tags
- ps1_m, ps2_m  out  WIDTH  source mapped (0 = read architectural reset value)
- pdst  out  WIDTH x TAG  registered new tag
- pold  out  WIDTH x TAG  registered previous tag of dst
- pold_m  out  WIDTH  previous mapping valid
- cmt_  in  COMMIT  active-low commit per slot
- cmt_dst  in  COMMIT x AREG  committed architectural destination
- cmt_tag  in  COMMIT x TAG  committed physical tag
- free_  out  COMMIT  registered active-low, to freelist we_
- free_tag  out  COMMIT x TAG  registered, to freelist wd

Behaviour:
- State:
  - spec map and committed map, ARCH entries each.
  - Each entry is {mapped bit, TAG}.
- Reset (synchronous, active-high):
  - All entries of both maps: mapped=0, tag=0.
  - out_v=0, free_=all 1, all registered tags 0.
- Stall:
  - stall = fl_busy OR (some k with ren_[k]=0 and fl_v[k]=0).
  - stall is combinational.
- Accept:
  - A group is accepted when stall=0 and flush_=1.
  - On accept, alloc_[k]=ren_[k]. Otherwise alloc_=all 1, so no freelist tag is consumed.
- Intra-group bypass, for slot k:
  - src1/src2/dst lookup takes fl_tag[j] (mapped=1) of the highest active j<k with dst[j] equal to the looked-up register.
  - Otherwise the lookup takes the spec map entry.
- Latency:
  - Outputs are registered, one cycle after accept.
  - out_v[k] = !ren_[k] for accepted cycles; otherwise 0.
  - pdst[k] = fl_tag[k].
- Spec map update on accept:
  - map[dst[k]] <= {1, fl_tag[k]} for each active slot.
  - When slots share a dst, the highest slot wins.
- Commit, independent of stall:
  - For each active slot c, old = the most recent of committed map[cmt_dst[c]] and cmt_tag[j] of the highest active j<c with the same dst.
  - Committed map[cmt_dst[c]] <= {1, cmt_tag[c]}, highest slot winning.
  - Next cycle: free_[c]=0 and free_tag[c]=old tag if old was mapped; else free_[c]=1.
- Flush (flush_=0):
  - spec map <= committed map, including this cycle's commit updates.
  - The rename group is ignored, alloc_=all 1, out_v<=0.
  - The commit and free path operate normally.
- Flush integration:
  - Squashed in-flight tags are returned by the reorder-buffer walk, not by this block.
  - The freelist flush_ is tied to full reset only.
- Rename and commit on the same architectural register in the same cycle: the spec map takes the rename and the committed map takes the commit.
- Reset asserted mid-group: discards all state, and no free_ is issued the following cycle.

Test Plan:
- Reset, then rename slot0 src1=3 dst=5, fl_tag[0]=7 -> next cycle: out_v=0001, ps1_m[0]=0, pdst[0]=7, pold_m[0]=0, alloc_=1110 during the accept cycle.
- Same group: slot0 dst=5 tag 9, slot1 src1=5 dst=5 tag 10 -> psrc1[1]=9 with ps1_m=1, pold[1]=9; a subsequent lookup of r5 returns 10.
- fl_v=1011 with ren_=0000 -> stall=1, alloc_=1111, spec map unchanged, out_v=0 next cycle; retry with fl_v=1111 is accepted.
- Commit r5 tag 9, then commit r5 tag 10 in later cycles -> first: free_=all 1; second: free_[0]=0, free_tag[0]=9 one cycle later.
- Two commit slots in the same cycle both to r2, tags 4 then 6, committed r2 previously tag 1 -> free_tag[0]=1, free_tag[1]=4, committed r2=6.
- Rename r5->12 (committed r5=10), then flush_=0 -> lookup r5 returns 10; the rename group presented during the flush cycle yields out_v=0 and alloc_=1111.
